pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed 2×32-bit IF/ID pipeline register.
- Generic pipeline-stage register with valid/ready handshake on both sides, an optional 2-entry skid buffer, a hazard stall input, a flush input, and saturating stall/flush event counters.
- Instanced between any two pipeline stages: IF/ID, ID/EX, EX/MEM, MEM/WB.
- Flushed entries clear to RESET_VAL, so that value must decode as a NOP downstream.

Parameters:
- DATA_W, 64: payload width; the IF/ID instance packs {addr, inst}.
- RESET_VAL, 0: payload value after reset or flush.
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready_o; 0 = single register with combinational ready pass-through.
- CNT_W, 16: width of each event counter.

Ports:
- clk_i, input, 1: clock; all state updates on the rising edge.
- rst_i, input, 1: synchronous, active-high reset.
- in_valid_i, input, 1: upstream beat valid.
- in_ready_o, output, 1: stage can accept a beat.
- in_data_i, input, DATA_W: upstream payload.
- out_valid_o, output, 1: downstream beat valid.
- out_ready_i, input, 1: downstream accepts.
- out_data_o, output, DATA_W: payload presented downstream.
- stall_i, input, 1: hazard hold; the stage freezes.
- flush_i, input, 1: kill all held and incoming beats.
- stall_cnt_o, output, CNT_W: cycles with stall_i=1 and main entry valid; saturating.
- flush_cnt_o, output, CNT_W: cycles with flush_i=1 that kill at least one valid entry; saturating.

Behaviour:
- Reset (rst_i=1 at clock edge): main_v=0, skid_v=0, both payload registers = RESET_VAL, both counters = 0. Outputs after reset: out_valid_o=0, out_data_o=RESET_VAL, in_ready_o=1 if SKID=1, else follows the formula below.
- Handshake: a beat transfers when valid and ready are both 1 in the same cycle. out_data_o is stable while out_valid_o=1 and out_ready_i=0.
- Latency: an accepted beat appears on out_data_o one cycle later when the stage was empty. Throughput is 1 beat/cycle when there is no backpressure.
- Priority, highest first: rst_i > flush_i > stall_i > normal handshake.
- Flush:
  - Next cycle main_v=0 and skid_v=0, and both payloads = RESET_VAL.
  - A beat offered the same cycle is consumed (in_ready_o is unaffected by flush) and discarded.
  - An out_ready_i=1 that cycle does not count as a transfer.
- Stall (with no flush):
  - out_valid_o and in_ready_o are forced to 0 combinationally.
  - All registers hold.
- SKID=1 state machine, state = {main_v, skid_v}:
  - EMPTY (0,0): an accept moves to FULL.
  - FULL (1,0):
    - accept with no output transfer → SKID (incoming beat goes to the skid register);
    - output transfer with no accept → EMPTY;
    - both → FULL, main loads the incoming beat.
  - SKID (1,1):
    - in_ready_o=0;
    - an output transfer moves the skid payload into main → FULL.
  - in_ready_o is registered and equals !skid_v (and !stall_i). It never depends combinationally on out_ready_i.
- SKID=0:
  - in_ready_o = !stall_i & (!main_v | out_ready_i).
  - Simultaneous output transfer and accept replaces main in the same edge.
- Counters:
  - +1 per qualifying cycle, saturating at all-ones (no wrap).
  - Cleared only by rst_i.
- Reset mid-operation: held beats are dropped with no output. out_valid_o=0 from the cycle after the reset edge.
- Ordering: beats leave in acceptance order, and none are duplicated or lost except by flush or reset.

Decomposition:
- Shared package pipe_pkg:
  - stage-state encoding (ST_EMPTY, ST_FULL, ST_SKID);
  - default NOP constant used as RESET_VAL;
  - IF/ID payload field offsets (ADDR_LSB=32, INST_LSB=0).
- One natural sub-module: sat_counter (parameter W; inputs clk_i, rst_i, inc_i; output cnt_o), instanced twice.

Test Plan:
- Reset and fill:
  - Stimulus: rst_i high 2 cycles, then in_valid_i=1 with in_data_i=0x00000004_00A00093, out_ready_i=1.
  - Required: out_valid_o=1 and out_data_o=0x00000004_00A00093 one cycle after the accept. Before it, out_valid_o=0 and out_data_o=0.
- Backpressure (SKID=1):
  - Stimulus: stream beats 1, 2, 3 with out_ready_i=0.
  - Required: beats 1 and 2 accepted, in_ready_o=0 in the cycle after beat 2 is accepted, beat 3 held upstream. After releasing out_ready_i, beats arrive in order 1, 2, 3 with no gaps.
- Stall:
  - Stimulus: stage FULL with 0xAB, stall_i=1 for 3 cycles, out_ready_i=1.
  - Required: out_valid_o=0 and in_ready_o=0 for those 3 cycles. Then 0xAB is delivered once, and stall_cnt_o=3.
- Flush in SKID state:
  - Stimulus: flush_i=1 for one cycle while in_valid_i=1.
  - Required: next cycle out_valid_o=0, out_data_o=RESET_VAL, in_ready_o=1, flush_cnt_o=1. The incoming beat never appears.
- Simultaneous flush and stall:
  - Stimulus: flush_i=1 and stall_i=1 in the same cycle.
  - Required: flush wins (stage empty next cycle), and stall_cnt_o increments by 1 for that cycle.
- Counter saturation (CNT_W=2):
  - Stimulus: stall_i=1 for 5 cycles with the main entry valid.
  - Required: stall_cnt_o reads 1, 2, 3, 3, 3.
- SKID=0 pass-through:
  - Stimulus: continuous in_valid_i and out_ready_i.
  - Required: 1 beat/cycle. When out_ready_i is dropped, in_ready_o falls in the same cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared encodings and constants for the generic pipeline stage.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Stage state is the pair {main_v, skid_v}
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_FULL  = 2'b10;
    localparam logic [1:0] ST_SKID  = 2'b11;

    // All-zero payload decodes as a NOP in every downstream stage
    localparam logic [63:0] PIPE_NOP = 64'h0;

    localparam int ADDR_LSB = 32;
    localparam int INST_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Event counter that sticks at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Brief    : Valid/ready pipeline register with optional 2-entry skid buffer,
//            hazard stall, flush and saturating stall/flush event counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(PIPE_NOP),
    parameter int                SKID      = 1,
    parameter int                CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] r_main_data;
    logic [DATA_W-1:0] r_skid_data;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] w_skid_nxt;
    logic              w_main_v;
    logic              w_skid_v;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_xfer;

    assign w_main_v = r_state[1];
    assign w_skid_v = r_state[0];

    // Skid mode derives ready purely from registered state, cutting the
    // out_ready_i -> in_ready_o combinational path.
    if (SKID != 0) begin : g_skid_ready
        assign w_in_ready = ~w_skid_v & ~stall_i;
    end else begin : g_pass_ready
        assign w_in_ready = ~stall_i & (~w_main_v | out_ready_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_EMPTY;
            r_main_data <= RESET_VAL;
            r_skid_data <= RESET_VAL;
        end else begin
            r_state     <= w_state_nxt;
            r_main_data <= w_main_nxt;
            r_skid_data <= w_skid_nxt;
        end
    end

    // With SKID=0 an accept in FULL always coincides with a transfer, so the
    // SKID state is never entered and one transition table serves both modes.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main_data;
        w_skid_nxt  = r_skid_data;
        if (flush_i) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = RESET_VAL;
            w_skid_nxt  = RESET_VAL;
        end else if (!stall_i) begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_FULL;
                        w_main_nxt  = in_data_i;
                    end
                end
                ST_FULL: begin
                    if (w_accept && !w_xfer) begin
                        w_state_nxt = ST_SKID;
                        w_skid_nxt  = in_data_i;
                    end else if (w_accept) begin
                        w_main_nxt  = in_data_i;
                    end else if (w_xfer) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (w_xfer) begin
                        w_state_nxt = ST_FULL;
                        w_main_nxt  = r_skid_data;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        w_out_valid = w_main_v & ~stall_i;
        w_accept    = in_valid_i & w_in_ready;
        w_xfer      = w_out_valid & out_ready_i & ~flush_i;
        in_ready_o  = w_in_ready;
        out_valid_o = w_out_valid;
        out_data_o  = r_main_data;
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_i & w_main_v),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_i & (w_main_v | w_skid_v)),
        .cnt_o (flush_cnt_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Brief    : Queue-model bench for the skid and pass-through stage variants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv1, ordy1, st1, fl1;
    logic [63:0] din1;
    logic        ir1, ov1;
    logic [63:0] dout1;
    logic [15:0] sc1, fc1;
    logic        ir2, ov2;
    logic [63:0] dout2;
    logic [1:0]  sc2, fc2;
    logic        iv0, ordy0, st0, fl0;
    logic [63:0] din0;
    logic        ir0, ov0;
    logic [63:0] dout0;
    logic [15:0] sc0, fc0;

    pipe_stage_skid u_dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv1), .in_ready_o(ir1), .in_data_i(din1),
        .out_valid_o(ov1), .out_ready_i(ordy1), .out_data_o(dout1), .stall_i(st1),
        .flush_i(fl1), .stall_cnt_o(sc1), .flush_cnt_o(fc1)
    );

    pipe_stage_skid #(.CNT_W(2)) u_sat (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv1), .in_ready_o(ir2), .in_data_i(din1),
        .out_valid_o(ov2), .out_ready_i(ordy1), .out_data_o(dout2), .stall_i(st1),
        .flush_i(fl1), .stall_cnt_o(sc2), .flush_cnt_o(fc2)
    );

    pipe_stage_skid #(.SKID(0)) u_pass (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv0), .in_ready_o(ir0), .in_data_i(din0),
        .out_valid_o(ov0), .out_ready_i(ordy0), .out_data_o(dout0), .stall_i(st0),
        .flush_i(fl0), .stall_cnt_o(sc0), .flush_cnt_o(fc0)
    );

    // Reference model: each stage is a FIFO of held beats (capacity 2 or 1)
    logic [63:0] q1[$];
    logic [63:0] q0[$];
    int  s1, f1, s0, f0;
    bit  known1, known0, acc1, acc0;
    int  tests = 0;
    int  fails = 0;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit er1, ev1, er0, ev0, x1, x0;
        @(negedge clk);
        er1 = !st1 && (q1.size() < 2);
        ev1 = !st1 && (q1.size() > 0);
        er0 = !st0 && ((q0.size() == 0) || ordy0);
        ev0 = !st0 && (q0.size() > 0);
        if (!rst) begin
            check("skid_in_ready", 64'(ir1), 64'(er1));
            check("skid_out_valid", 64'(ov1), 64'(ev1));
            if (q1.size() > 0) check("skid_data", dout1, q1[0]);
            else if (known1)   check("skid_data_nop", dout1, 64'h0);
            check("skid_stall_cnt", 64'(sc1), 64'(sat(s1, 65535)));
            check("skid_flush_cnt", 64'(fc1), 64'(sat(f1, 65535)));
            check("sat_in_ready", 64'(ir2), 64'(er1));
            check("sat_out_valid", 64'(ov2), 64'(ev1));
            if (q1.size() > 0) check("sat_data", dout2, q1[0]);
            check("sat_stall_cnt", 64'(sc2), 64'(sat(s1, 3)));
            check("sat_flush_cnt", 64'(fc2), 64'(sat(f1, 3)));
            check("pass_in_ready", 64'(ir0), 64'(er0));
            check("pass_out_valid", 64'(ov0), 64'(ev0));
            if (q0.size() > 0) check("pass_data", dout0, q0[0]);
            else if (known0)   check("pass_data_nop", dout0, 64'h0);
            check("pass_stall_cnt", 64'(sc0), 64'(sat(s0, 65535)));
            check("pass_flush_cnt", 64'(fc0), 64'(sat(f0, 65535)));
        end
        acc1 = iv1 && er1;
        x1   = ev1 && ordy1 && !fl1;
        acc0 = iv0 && er0;
        x0   = ev0 && ordy0 && !fl0;
        if (rst) begin
            q1.delete(); q0.delete();
            s1 = 0; f1 = 0; s0 = 0; f0 = 0;
            known1 = 1; known0 = 1; acc1 = 0; acc0 = 0;
        end else begin
            if (st1 && q1.size() > 0) s1++;
            if (fl1 && q1.size() > 0) f1++;
            if (fl1) begin
                q1.delete(); known1 = 1;
            end else begin
                if (x1) void'(q1.pop_front());
                if (acc1) begin q1.push_back(din1); known1 = 0; end
            end
            if (st0 && q0.size() > 0) s0++;
            if (fl0 && q0.size() > 0) f0++;
            if (fl0) begin
                q0.delete(); known0 = 1;
            end else begin
                if (x0) void'(q0.pop_front());
                if (acc0) begin q0.push_back(din0); known0 = 0; end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [63:0] d);
        int n;
        iv1  = 1'b1;
        din1 = d;
        n    = 0;
        do begin
            tick();
            n++;
        end while (!acc1 && n < 20);
        if (!acc1) check("send_timeout", 64'(ir1), 64'h1);
        iv1 = 1'b0;
    endtask

    task automatic drain1();
        iv1 = 0; st1 = 0; fl1 = 0; ordy1 = 1;
        repeat (3) tick();
    endtask

    int          sat_exp[5] = '{1, 2, 3, 3, 3};
    int          prev_s1;

    initial begin
        rst = 1; iv1 = 0; ordy1 = 0; st1 = 0; fl1 = 0; din1 = '0;
        iv0 = 0; ordy0 = 0; st0 = 0; fl0 = 0; din0 = '0;
        tick(); tick();
        rst = 0;
        #1;
        check("rst_valid", 64'(ov1), 64'h0);
        check("rst_data", dout1, 64'h0);
        check("rst_ready", 64'(ir1), 64'h1);

        // Reset and fill
        ordy1 = 1;
        send1(64'h00000004_00A00093);
        check("fill_valid", 64'(ov1), 64'h1);
        check("fill_data", dout1, 64'h00000004_00A00093);
        drain1();

        // Backpressure: 1 and 2 held, 3 waits upstream, then in-order release
        ordy1 = 0;
        send1(64'h1);
        send1(64'h2);
        check("bp_ready_low", 64'(ir1), 64'h0);
        ordy1 = 1;
        send1(64'h3);
        drain1();

        // Stall with 0xAB held
        ordy1 = 0;
        send1(64'hAB);
        st1 = 1; ordy1 = 1;
        repeat (3) begin
            #1;
            check("stall_valid", 64'(ov1), 64'h0);
            check("stall_ready", 64'(ir1), 64'h0);
            tick();
        end
        st1 = 0;
        tick();
        check("stall_cnt3", 64'(sc1), 64'd3);
        drain1();

        // Reset mid-operation drops held beats
        ordy1 = 0;
        send1(64'h5);
        send1(64'h6);
        rst = 1;
        tick(); tick();
        rst = 0;
        #1;
        check("midrst_valid", 64'(ov1), 64'h0);

        // Counter saturation on the 2-bit instance
        send1(64'h7);
        st1 = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("sat_seq", 64'(sc2), 64'(sat_exp[i]));
        end
        st1 = 0;

        // Flush while in SKID state with an incoming beat
        send1(64'h8);
        iv1 = 1; din1 = 64'hDEAD; fl1 = 1;
        tick();
        iv1 = 0; fl1 = 0;
        #1;
        check("flush_valid", 64'(ov1), 64'h0);
        check("flush_data", dout1, 64'h0);
        check("flush_ready", 64'(ir1), 64'h1);
        check("flush_cnt1", 64'(fc1), 64'h1);
        drain1();

        // Simultaneous flush and stall
        ordy1 = 0;
        send1(64'h9);
        prev_s1 = s1;
        fl1 = 1; st1 = 1;
        tick();
        fl1 = 0; st1 = 0;
        #1;
        check("fs_valid", 64'(ov1), 64'h0);
        check("fs_ready", 64'(ir1), 64'h1);
        check("fs_stall_cnt", 64'(sc1), 64'(prev_s1 + 1));
        drain1();

        // Pass-through: one beat per cycle, ready follows out_ready_i at once
        ordy0 = 1; iv0 = 1;
        for (int i = 0; i < 6; i++) begin
            din0 = 64'h100 + 64'(i);
            tick();
            check("pt_valid", 64'(ov0), 64'h1);
        end
        ordy0 = 0;
        #1;
        check("pt_ready_drop", 64'(ir0), 64'h0);
        iv0 = 0;
        tick();
        ordy0 = 1;
        tick(); tick();

        // Randomised traffic on both variants
        for (int i = 0; i < 400; i++) begin
            iv1   = 1'($urandom_range(0, 1));
            ordy1 = 1'($urandom_range(0, 1));
            st1   = ($urandom_range(0, 9) == 0);
            fl1   = ($urandom_range(0, 19) == 0);
            din1  = {$urandom, $urandom};
            iv0   = 1'($urandom_range(0, 1));
            ordy0 = 1'($urandom_range(0, 1));
            st0   = ($urandom_range(0, 9) == 0);
            fl0   = ($urandom_range(0, 19) == 0);
            din0  = {$urandom, $urandom};
            tick();
        end
        iv1 = 0; st1 = 0; fl1 = 0; ordy1 = 1;
        iv0 = 0; st0 = 0; fl0 = 0; ordy0 = 1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
